bcd2bin_seq: RTL and testbench

- Parametrised multi-cycle BCD-to-binary converter. It is the successor to the fixed-width serial BCD converter.
- Converts N_DIGITS packed BCD digits to an unsigned binary value using the reverse double-dabble method: shift right one bit per cycle, then subtract 3 from any digit that is 8 or more.
- Sits between the keypad/BCD entry logic and the binary arithmetic datapath.
- Uses a start/ready/done handshake. The result is held until the next accepted start.

---
 rtl/bcd2bin_seq.sv | 136 +++++++++++++
 tb/tb_bcd2bin_seq.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd2bin_seq.sv
// Multi-cycle packed-BCD to binary converter (reverse double-dabble), start/ready/done handshake.
// Optional invalid-digit rejection is enabled by defining BCD2BIN_DIGIT_CHECK_EN.
module bcd2bin_seq #(
  parameter int N_DIGITS = 4,
  parameter int BIN_W    = 14
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [4*N_DIGITS-1:0]   i_bcd,
  output logic                    o_ready,
  output logic                    o_done,
  output logic [BIN_W-1:0]        o_bin,
  output logic                    o_err
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t             state;
  logic [BCD_W-1:0]   bcd_q;
  logic [BCD_W-1:0]   bcd_shifted;
  logic [BIN_W-1:0]   bin_q;
  logic [BIN_W-1:0]   bin_shifted;
  logic [CNT_W-1:0]   cnt_q;

  // Per-digit 4-bit correction; digits never carry into their neighbours.
  function automatic logic [BCD_W-1:0] correct_digits(input logic [BCD_W-1:0] x);
    logic [BCD_W-1:0] r;
    logic [3:0]       d;
    r = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      d = x[4*k +: 4];
      if (d >= 4'd8) d = d - 4'd3;
      r[4*k +: 4] = d;
    end
    return r;
  endfunction

  always_comb begin
    bcd_shifted = correct_digits({1'b0, bcd_q[BCD_W-1:1]});
    bin_shifted = {bcd_q[0], bin_q[BIN_W-1:1]};
  end

  assign o_bin = bin_q;

`ifdef BCD2BIN_DIGIT_CHECK_EN
  logic bad_digit;
  logic err_q;

  function automatic logic has_bad_digit(input logic [BCD_W-1:0] x);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (x[4*k +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  always_comb bad_digit = has_bad_digit(i_bcd);

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= S_IDLE;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      o_ready <= 1'b1;
      o_done  <= 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            bin_q   <= '0;
            o_ready <= 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            // Rejected inputs bypass the shift loop and report straight away.
            if (bad_digit) begin
              bcd_q  <= '0;
              cnt_q  <= '0;
              err_q  <= 1'b1;
              o_done <= 1'b1;
              state  <= S_DONE;
            end else
`endif
            begin
`ifdef BCD2BIN_DIGIT_CHECK_EN
              err_q <= 1'b0;
`endif
              bcd_q <= i_bcd;
              cnt_q <= CNT_W'(BIN_W);
              state <= S_SHIFT;
            end
          end
        end

        S_SHIFT: begin
          bcd_q <= bcd_shifted;
          bin_q <= bin_shifted;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            o_done <= 1'b1;
            state  <= S_DONE;
          end
        end

        S_DONE: begin
          o_done  <= 1'b0;
          o_ready <= 1'b1;
          state   <= S_IDLE;
        end

        default: begin
          o_done  <= 1'b0;
          o_ready <= 1'b1;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed self-checking bench for bcd2bin_seq: default 4-digit instance plus 1/2/3-digit sweep instances.
module tb_bcd2bin_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] bcd;
  logic        ready, done, err;
  logic [13:0] bin;

  logic        s1_start, s1_ready, s1_done, s1_err;
  logic [3:0]  s1_bcd;
  logic [3:0]  s1_bin;
  logic        s2_start, s2_ready, s2_done, s2_err;
  logic [7:0]  s2_bcd;
  logic [6:0]  s2_bin;
  logic        s3_start, s3_ready, s3_done, s3_err;
  logic [11:0] s3_bcd;
  logic [9:0]  s3_bin;

  int tests_run;
  int tests_failed;
  int cyc;

  bcd2bin_seq #(.N_DIGITS(4), .BIN_W(14)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_bcd(bcd),
    .o_ready(ready), .o_done(done), .o_bin(bin), .o_err(err)
  );

  bcd2bin_seq #(.N_DIGITS(1), .BIN_W(4)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(s1_start), .i_bcd(s1_bcd),
    .o_ready(s1_ready), .o_done(s1_done), .o_bin(s1_bin), .o_err(s1_err)
  );

  bcd2bin_seq #(.N_DIGITS(2), .BIN_W(7)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(s2_start), .i_bcd(s2_bcd),
    .o_ready(s2_ready), .o_done(s2_done), .o_bin(s2_bin), .o_err(s2_err)
  );

  bcd2bin_seq #(.N_DIGITS(3), .BIN_W(10)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_start(s3_start), .i_bcd(s3_bcd),
    .o_ready(s3_ready), .o_done(s3_done), .o_bin(s3_bin), .o_err(s3_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges after the current point until o_done is seen (0 if already high).
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done && cycles < 60) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0; bcd = '0;
    s1_start = 1'b0; s1_bcd = '0;
    s2_start = 1'b0; s2_bcd = '0;
    s3_start = 1'b0; s3_bcd = '0;
    tick(); tick();
    tests_run++;
    if (ready !== 1'b1 || done !== 1'b0 || bin !== 14'd0 || err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_values: ready=%b done=%b bin=%0d err=%b, want 1 0 0 0", ready, done, bin, err);
    end
    rst = 1'b0;
    tick();
    tests_run++;
    if (ready !== 1'b1 || done !== 1'b0 || bin !== 14'd0) begin
      tests_failed++;
      $display("[TB] FAIL idle_after_reset: ready=%b done=%b bin=%0d, want 1 0 0", ready, done, bin);
    end
  endtask

  task automatic test_single();
    int c;
    start = 1'b1; bcd = 16'h9999;
    tick();
    start = 1'b0;
    tests_run++;
    if (ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL ready_drop: ready=%b, want 0", ready);
    end
    wait_done(c);
    tests_run++;
    if (c != 14) begin
      tests_failed++;
      $display("[TB] FAIL latency_9999: %0d cycles, want 14", c);
    end
    tests_run++;
    if (bin !== 14'd9999 || ready !== 1'b0 || err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL result_9999: bin=%0d ready=%b err=%b, want 9999 0 0", bin, ready, err);
    end
    tick();
    tests_run++;
    if (ready !== 1'b1 || done !== 1'b0 || bin !== 14'd9999) begin
      tests_failed++;
      $display("[TB] FAIL hold_9999: ready=%b done=%b bin=%0d, want 1 0 9999", ready, done, bin);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vec [3];
    logic [13:0] exp [3];
    int c;
    int last;
    vec[0] = 16'h0000; exp[0] = 14'd0;
    vec[1] = 16'h0001; exp[1] = 14'd1;
    vec[2] = 16'h1000; exp[2] = 14'd1000;
    last = 0;
    start = 1'b1; bcd = vec[0];
    for (int i = 0; i < 3; i++) begin
      wait_done(c);
      if (i < 2) bcd = vec[i+1];
      else start = 1'b0;
      tests_run++;
      if (!done || bin !== exp[i]) begin
        tests_failed++;
        $display("[TB] FAIL b2b_result_%0d: done=%b bin=%0d, want 1 %0d", i, done, bin, exp[i]);
      end
      if (i > 0) begin
        tests_run++;
        if (cyc - last != 16) begin
          tests_failed++;
          $display("[TB] FAIL b2b_gap_%0d: %0d cycles, want 16", i, cyc - last);
        end
      end
      last = cyc;
      tick();
    end
    tick();
  endtask

  task automatic test_ignore_start();
    int pulses;
    logic [13:0] got;
    pulses = 0; got = '0;
    start = 1'b1; bcd = 16'h4321;
    tick();
    for (int i = 0; i < 8; i++) begin
      start = (i % 2 == 0);
      bcd = 16'h8888;
      tick();
    end
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done) begin
        pulses++;
        if (pulses == 1) got = bin;
      end
      tick();
    end
    tests_run++;
    if (pulses != 1) begin
      tests_failed++;
      $display("[TB] FAIL ignore_pulses: %0d done pulses, want 1", pulses);
    end
    tests_run++;
    if (got !== 14'd4321) begin
      tests_failed++;
      $display("[TB] FAIL ignore_result: bin=%0d, want 4321", got);
    end
  endtask

  task automatic test_mid_reset();
    int c;
    start = 1'b1; bcd = 16'h5678;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    #1;
    tests_run++;
    if (bin !== 14'd0 || done !== 1'b0 || ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset: bin=%0d done=%b ready=%b, want 0 0 1", bin, done, ready);
    end
    tick();
    rst = 1'b0;
    tick();
    start = 1'b1; bcd = 16'h0042;
    tick();
    start = 1'b0;
    wait_done(c);
    tests_run++;
    if (c != 14 || bin !== 14'd42) begin
      tests_failed++;
      $display("[TB] FAIL after_reset_42: cycles=%0d bin=%0d, want 14 42", c, bin);
    end
    tick();
  endtask

`ifdef BCD2BIN_DIGIT_CHECK_EN
  task automatic test_digit_check();
    int c;
    start = 1'b1; bcd = 16'h12A4;
    tick();
    start = 1'b0;
    wait_done(c);
    tests_run++;
    if (c != 0 || err !== 1'b1 || bin !== 14'd0) begin
      tests_failed++;
      $display("[TB] FAIL bad_digit: cycles=%0d err=%b bin=%0d, want 0 1 0", c, err, bin);
    end
    tick();
    tests_run++;
    if (err !== 1'b1 || ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL err_hold: err=%b ready=%b, want 1 1", err, ready);
    end
    start = 1'b1; bcd = 16'h0012;
    tick();
    start = 1'b0;
    wait_done(c);
    tests_run++;
    if (c != 14 || err !== 1'b0 || bin !== 14'd12) begin
      tests_failed++;
      $display("[TB] FAIL after_bad_12: cycles=%0d err=%b bin=%0d, want 14 0 12", c, err, bin);
    end
    tick();
  endtask
`endif

  task automatic test_sweep();
    int c;
    int t;
    for (int v = 0; v < 10; v++) begin
      s1_bcd = 4'(v); s1_start = 1'b1;
      tick();
      s1_start = 1'b0;
      c = 0;
      while (!s1_done && c < 30) begin tick(); c++; end
      tests_run++;
      if (c != 4 || s1_bin !== 4'(v) || s1_err !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL sweep1_%0d: cycles=%0d bin=%0d, want 4 %0d", v, c, s1_bin, v);
      end
      tick();
    end
    for (int v = 0; v < 100; v++) begin
      s2_bcd = {4'(v / 10), 4'(v % 10)}; s2_start = 1'b1;
      tick();
      s2_start = 1'b0;
      c = 0;
      while (!s2_done && c < 30) begin tick(); c++; end
      tests_run++;
      if (c != 7 || s2_bin !== 7'(v) || s2_err !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL sweep2_%0d: cycles=%0d bin=%0d, want 7 %0d", v, c, s2_bin, v);
      end
      tick();
    end
    for (int v = 0; v < 1000; v++) begin
      t = v;
      for (int k = 0; k < 3; k++) begin
        s3_bcd[4*k +: 4] = 4'(t % 10);
        t = t / 10;
      end
      s3_start = 1'b1;
      tick();
      s3_start = 1'b0;
      c = 0;
      while (!s3_done && c < 30) begin tick(); c++; end
      tests_run++;
      if (c != 10 || s3_bin !== 10'(v) || s3_err !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL sweep3_%0d: cycles=%0d bin=%0d, want 10 %0d", v, c, s3_bin, v);
      end
      tick();
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore_start();
    test_mid_reset();
`ifdef BCD2BIN_DIGIT_CHECK_EN
    test_digit_check();
`endif
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
